// File: rtl/cfg_push_ctrl_if.sv
// Signal bundle between the push controller, the board inputs and the register bank.
// master is the controller's side; slave is the board/bank side.
interface cfg_push_ctrl_if;
  logic       btn_next;
  logic       btn_load;
  logic [4:0] sw_mask;
  logic       clk_locked;
  logic [2:0] h_select;
  logic       push;
  logic       clk_wiz_rst;
  logic       vga_rst;
  logic       sha_rst;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  btn_next, btn_load, sw_mask, clk_locked,
    output h_select, push, clk_wiz_rst, vga_rst, sha_rst, busy, timeout_err
  );

  modport slave (
    output btn_next, btn_load, sw_mask, clk_locked,
    input  h_select, push, clk_wiz_rst, vga_rst, sha_rst, busy, timeout_err
  );
endinterface

// File: rtl/cfg_push_ctrl.sv
// Button debounce, register-select stepping, push strobe and ordered sub-block
// reset sequencing (clock wizard -> lock wait -> VGA -> SHA).
module cfg_push_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned NUM_REGS        = 6,
  parameter int unsigned RST_PULSE       = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65535
) (
  input  logic           clk,
  input  logic           rst,
  cfg_push_ctrl_if.master bus
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CMAX = (LOCK_TIMEOUT > RST_PULSE) ? LOCK_TIMEOUT : RST_PULSE;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, PUSH, WIZ_RST, WAIT_LOCK, VGA_RST, SHA_RST, DONE
  } state_t;

  // Button index 0 = next, 1 = load
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q, acc_q, prev_q;
  logic [DW-1:0] dcnt_q [2];
  logic [1:0]    rise;

  assign btn_raw = {bus.btn_load, bus.btn_next};
  assign rise    = acc_q & ~prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      prev_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= acc_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          acc_q[i]  <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mask_q, mask_d;   // {wiz, vga, sha}
  logic [2:0]    hsel_q, hsel_d;
  logic          push_q, push_d, wiz_q, wiz_d, vga_q, vga_d, sha_q, sha_d;
  logic          busy_q, busy_d, tmo_q, tmo_d;
  logic          tmo_set, pulse_done;
  logic          unused_sw;

  assign unused_sw  = ^bus.sw_mask[3:2];
  assign pulse_done = (cnt_q == CW'(RST_PULSE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      hsel_q  <= '0;
      push_q  <= 1'b0;
      wiz_q   <= 1'b0;
      vga_q   <= 1'b0;
      sha_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      hsel_q  <= hsel_d;
      push_q  <= push_d;
      wiz_q   <= wiz_d;
      vga_q   <= vga_d;
      sha_q   <= sha_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_set = 1'b0;
    case (state_q)
      IDLE:      if (rise[1]) state_d = PUSH;
      PUSH: begin
        if (hsel_q == '0 && mask_q != '0)
          state_d = mask_q[2] ? WIZ_RST : (mask_q[1] ? VGA_RST : SHA_RST);
        else
          state_d = IDLE;
      end
      WIZ_RST:   if (pulse_done) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (bus.clk_locked) begin
          state_d = mask_q[1] ? VGA_RST : (mask_q[0] ? SHA_RST : DONE);
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = DONE;
          tmo_set = 1'b1;
        end
      end
      VGA_RST:   if (pulse_done) state_d = mask_q[0] ? SHA_RST : DONE;
      SHA_RST:   if (pulse_done) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // One counter serves both pulse length and lock wait; it restarts on every state change
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so the registered copies line up with the state register
  always_comb begin
    push_d = (state_d == PUSH);
    wiz_d  = (state_d == WIZ_RST);
    vga_d  = (state_d == VGA_RST);
    sha_d  = (state_d == SHA_RST);
    busy_d = (state_d != IDLE);
    tmo_d  = tmo_q | tmo_set;
    hsel_d = hsel_q;
    mask_d = mask_q;
    if (state_q == IDLE) begin
      if (rise[1])
        mask_d = {bus.sw_mask[4], bus.sw_mask[1], bus.sw_mask[0]};
      else if (rise[0])
        hsel_d = (hsel_q == 3'(NUM_REGS - 1)) ? '0 : hsel_q + 1'b1;
    end
  end

  assign bus.h_select    = hsel_q;
  assign bus.push        = push_q;
  assign bus.clk_wiz_rst = wiz_q;
  assign bus.vga_rst     = vga_q;
  assign bus.sha_rst     = sha_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_cfg_push_ctrl.sv
// Self-checking bench for cfg_push_ctrl: each load is compared cycle by cycle
// against an expected output trace built from the stage rules.
module tb_cfg_push_ctrl;
  localparam int DEB = 4;
  localparam int NR  = 6;
  localparam int PUL = 3;
  localparam int TMO = 20;
  localparam int WIN = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cfg_push_ctrl_if bus();

  cfg_push_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_REGS(NR),
    .RST_PULSE(PUL),
    .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int m_hsel = 0;
  bit m_tmo  = 0;

  // {h_select[2:0], push, clk_wiz_rst, vga_rst, sha_rst, busy, timeout_err}
  typedef logic [8:0] vec_t;
  vec_t exp_tr [WIN];

  function automatic vec_t obs();
    return {bus.h_select, bus.push, bus.clk_wiz_rst, bus.vga_rst,
            bus.sha_rst, bus.busy, bus.timeout_err};
  endfunction

  function automatic vec_t mk(input int h, input bit p, input bit w, input bit v,
                              input bit s, input bit b, input bit tm);
    return {h[2:0], p, w, v, s, b, tm};
  endfunction

  // Trace index 0 is the push cycle; lock_t is the index at whose end clk_locked is first sampled high (-1: never)
  task automatic build_expected(input int hsel, input logic [4:0] mask, input int lock_t);
    int cur, wl;
    bit to;
    logic [2:0] en;
    en = {mask[4], mask[1], mask[0]};
    to = 0;
    for (int t = 0; t < WIN; t++) exp_tr[t] = mk(hsel, 0, 0, 0, 0, 0, m_tmo);
    exp_tr[0] = mk(hsel, 1, 0, 0, 0, 1, m_tmo);
    if (hsel == 0 && en != 3'b000) begin
      cur = 1;
      if (en[2]) begin
        for (int k = 0; k < PUL; k++) exp_tr[cur + k] = mk(hsel, 0, 1, 0, 0, 1, m_tmo);
        cur += PUL;
        if (lock_t < 0) wl = TMO + 1;
        else if (lock_t < cur) wl = 1;
        else wl = lock_t - cur + 1;
        if (wl > TMO) begin to = 1; wl = TMO; end
        for (int k = 0; k < wl; k++) exp_tr[cur + k] = mk(hsel, 0, 0, 0, 0, 1, m_tmo);
        cur += wl;
      end
      if (!to && en[1]) begin
        for (int k = 0; k < PUL; k++) exp_tr[cur + k] = mk(hsel, 0, 0, 1, 0, 1, m_tmo);
        cur += PUL;
      end
      if (!to && en[0]) begin
        for (int k = 0; k < PUL; k++) exp_tr[cur + k] = mk(hsel, 0, 0, 0, 1, 1, m_tmo);
        cur += PUL;
      end
      exp_tr[cur] = mk(hsel, 0, 0, 0, 0, 1, m_tmo);
      if (to) begin
        m_tmo = 1;
        for (int t = cur; t < WIN; t++) exp_tr[t][0] = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [4:0] mask, input int lock_t, input bit with_next,
                         input string name);
    bit found;
    bus.sw_mask = mask;
    build_expected(m_hsel, mask, lock_t);
    bus.btn_load = 1'b1;
    if (with_next) bus.btn_next = 1'b1;
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (bus.push === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s push_seen: got no push, required push within 60 cycles", name);
    end else begin
      for (int t = 0; t < WIN; t++) begin
        if (t > 0) @(negedge clk);
        total++;
        if (obs() !== exp_tr[t]) begin
          bad++;
          $display("FAIL %s trace t=%0d: got %b required %b", name, t, obs(), exp_tr[t]);
        end
        if (t == lock_t) bus.clk_locked = 1'b1;
      end
    end
    bus.btn_load   = 1'b0;
    bus.btn_next   = 1'b0;
    bus.clk_locked = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic press_next(input string name);
    bus.btn_next = 1'b1;
    repeat (DEB + 8) @(negedge clk);
    m_hsel = (m_hsel + 1) % NR;
    total++;
    if (bus.h_select !== 3'(m_hsel)) begin
      bad++;
      $display("FAIL %s h_select: got %0d required %0d", name, bus.h_select, m_hsel);
    end
    bus.btn_next = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic goto_sel(input int target);
    for (int i = 0; i < NR && m_hsel != target; i++) press_next("goto");
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== 9'b0) begin
      bad++;
      $display("FAIL reset_values: got %b required %b", obs(), 9'b0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch_next();
    for (int g = 0; g < 3; g++) begin
      bus.btn_next = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_next = 1'b0;
      repeat (8) @(negedge clk);
    end
    total++;
    if (bus.h_select !== 3'(m_hsel)) begin
      bad++;
      $display("FAIL glitch_ignored: got h_select=%0d required %0d", bus.h_select, m_hsel);
    end
    for (int i = 0; i < 6; i++) press_next("clean_next");
  endtask

  task automatic test_plain_push();
    goto_sel(2);
    do_load(5'b10011, -1, 0, "plain_push");
  endtask

  task automatic test_full_seq();
    goto_sel(0);
    do_load(5'b10011, 8, 0, "full_seq");
  endtask

  task automatic test_sha_only();
    goto_sel(0);
    do_load(5'b00001, -1, 0, "sha_only");
  endtask

  task automatic test_timeout();
    goto_sel(0);
    do_load(5'b10011, -1, 0, "timeout");
    do_load(5'b00010, -1, 0, "after_timeout");
  endtask

  task automatic test_simultaneous();
    goto_sel(3);
    do_load(5'b10011, -1, 1, "simultaneous");
    total++;
    if (bus.h_select !== 3'd3) begin
      bad++;
      $display("FAIL simult_hold: got h_select=%0d required 3", bus.h_select);
    end
  endtask

  task automatic test_random();
    logic [4:0] mask;
    int lt;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) goto_sel(0);
      else repeat ($urandom_range(0, 2)) press_next("rand_next");
      mask = 5'($urandom);
      lt = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 30));
      do_load(mask, lt, 0, "random");
    end
  endtask

  task automatic test_async_reset();
    bit found;
    goto_sel(0);
    bus.sw_mask    = 5'b10011;
    bus.clk_locked = 1'b1;
    bus.btn_load   = 1'b1;
    found = 0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (bus.vga_rst === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL async_vga_seen: got no vga_rst, required vga_rst within 80 cycles");
    end
    #2;
    rst = 1'b0;
    bus.btn_load   = 1'b0;
    bus.clk_locked = 1'b0;
    #1;
    total++;
    if (obs() !== 9'b0) begin
      bad++;
      $display("FAIL async_reset: got %b required %b", obs(), 9'b0);
    end
    m_hsel = 0;
    m_tmo  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (DEB + 8) @(negedge clk);
    total++;
    if (obs() !== 9'b0) begin
      bad++;
      $display("FAIL after_async_reset: got %b required %b", obs(), 9'b0);
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.btn_next   = 1'b0;
    bus.btn_load   = 1'b0;
    bus.sw_mask    = '0;
    bus.clk_locked = 1'b0;
    test_reset();
    test_glitch_next();
    test_plain_push();
    test_full_seq();
    test_sha_only();
    test_timeout();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
